multi_roi_centroid: RTL

- Parametrised successor to the single-band line centroid stage.
- Takes the 4-bit edge-magnitude stream and splits the bottom of the frame into NUM_ROI horizontal bands.
- Per band: counts above-threshold pixels, sums their x positions, and at frame end computes the mean x with a shared serial divider.
- Feeds band centroids and line-tracking status (valid/lost with frame hysteresis) to the steering/display logic.

---
 rtl/multi_roi_centroid.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/multi_roi_centroid.sv
// Per-band edge centroid for the bottom NUM_ROI bands of the frame, with one shared serial divider.
// Optional SOF_RESYNC_EN adds a sof input that realigns the pixel position to x=0, y=0.
module multi_roi_centroid #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int PIX_W       = 4,
  parameter int NUM_ROI     = 4,
  parameter int ROI_HEIGHT  = 32,
  parameter int THRESHOLD   = 2,
  parameter int MIN_COUNT   = 8,
  parameter int LOST_FRAMES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       pixel_in,
  input  logic                   in_ready,
`ifdef SOF_RESYNC_EN
  input  logic                   sof,
`endif
  output logic [11*NUM_ROI-1:0]  centroid_x,
  output logic [NUM_ROI-1:0]     roi_valid,
  output logic                   line_valid,
  output logic                   line_lost,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   overrun
);

  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SUM_W = $clog2(IMG_W * IMG_W * ROI_HEIGHT);
  localparam int CNT_W = 15;
  localparam int CX_W  = 11;
  localparam int RW    = (SUM_W > CNT_W + CX_W - 1) ? SUM_W : CNT_W + CX_W - 1;
  localparam int KW    = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1;
  localparam int MW    = $clog2(LOST_FRAMES + 1);

  localparam logic [XW-1:0]   X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]   Y_LAST   = YW'(IMG_H - 1);
  localparam logic [KW-1:0]   K_LAST   = KW'(NUM_ROI - 1);
  localparam logic [MW-1:0]   M_MAX    = MW'(LOST_FRAMES);
  localparam logic [3:0]      I_LAST   = 4'(CX_W - 1);
  localparam logic [CX_W-1:0] CX_RESET = CX_W'(IMG_W / 2);

  typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, DONE} state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      xPos_q, xPos_d, curX;
  logic [YW-1:0]      yPos_q, yPos_d, curY;
  logic               resync, lastPix, isEdge, clearAcc, startDiv;
  logic               frameEnd_q;
  logic [NUM_ROI-1:0] addEn;
  logic [SUM_W-1:0]   sum_q [NUM_ROI];
  logic [SUM_W-1:0]   sum_d [NUM_ROI];
  logic [CNT_W-1:0]   cnt_q [NUM_ROI];
  logic [CNT_W-1:0]   cnt_d [NUM_ROI];
  logic [SUM_W-1:0]   snapSum_q [NUM_ROI];
  logic [CNT_W-1:0]   snapCnt_q [NUM_ROI];
  logic [KW-1:0]      band_q, band_d;
  logic [3:0]         iter_q, iter_d;
  logic [RW-1:0]      rem_q, rem_d, den_q, den_d;
  logic [CX_W-1:0]    quo_q, quo_d;
  logic [CX_W-1:0]    cent_q [NUM_ROI];
  logic [CX_W-1:0]    cent_d [NUM_ROI];
  logic [NUM_ROI-1:0] roiValid_q, roiValid_d;
  logic [MW-1:0]      miss_q, miss_d;
  logic               lineLost_q, lineLost_d;

  always_comb begin
`ifdef SOF_RESYNC_EN
    resync = in_ready && sof;
`else
    resync = 1'b0;
`endif
    curX    = resync ? '0 : xPos_q;
    curY    = resync ? '0 : yPos_q;
    lastPix = in_ready && (curX == X_LAST) && (curY == Y_LAST);
    isEdge  = (pixel_in >= PIX_W'(THRESHOLD));
    xPos_d  = xPos_q;
    yPos_d  = yPos_q;
    if (in_ready) begin
      if (curX == X_LAST) begin
        xPos_d = '0;
        yPos_d = (curY == Y_LAST) ? '0 : curY + YW'(1);
      end else begin
        xPos_d = curX + XW'(1);
        yPos_d = curY;
      end
    end
    // A clear keeps the pixel of the same cycle, which already belongs to the new frame
    clearAcc = frameEnd_q || resync;
    startDiv = frameEnd_q && (state_q == IDLE);
    addEn    = '0;
    for (int k = 0; k < NUM_ROI; k++) begin
      addEn[k] = in_ready && isEdge &&
                 (int'(curY) >= IMG_H - (k + 1) * ROI_HEIGHT) &&
                 (int'(curY) <= IMG_H - k * ROI_HEIGHT - 1);
      sum_d[k] = clearAcc ? '0 : sum_q[k];
      cnt_d[k] = clearAcc ? '0 : cnt_q[k];
      if (addEn[k]) begin
        sum_d[k] = sum_d[k] + SUM_W'(curX);
        cnt_d[k] = cnt_d[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xPos_q     <= '0;
      yPos_q     <= '0;
      frameEnd_q <= 1'b0;
      for (int k = 0; k < NUM_ROI; k++) begin
        sum_q[k]     <= '0;
        cnt_q[k]     <= '0;
        snapSum_q[k] <= '0;
        snapCnt_q[k] <= '0;
      end
    end else begin
      xPos_q     <= xPos_d;
      yPos_q     <= yPos_d;
      frameEnd_q <= lastPix;
      for (int k = 0; k < NUM_ROI; k++) begin
        sum_q[k] <= sum_d[k];
        cnt_q[k] <= cnt_d[k];
        if (startDiv) begin
          snapSum_q[k] <= sum_q[k];
          snapCnt_q[k] <= cnt_q[k];
        end
      end
    end
  end

  // Every band takes the full LOAD/DIV/STORE path so frame latency never depends on data
  always_comb begin
    state_d    = state_q;
    band_d     = band_q;
    iter_d     = iter_q;
    rem_d      = rem_q;
    den_d      = den_q;
    quo_d      = quo_q;
    cent_d     = cent_q;
    roiValid_d = roiValid_q;
    miss_d     = miss_q;
    lineLost_d = lineLost_q;
    unique case (state_q)
      IDLE: begin
        band_d = '0;
        if (startDiv) state_d = LOAD;
      end
      LOAD: begin
        rem_d   = RW'(snapSum_q[band_q]);
        den_d   = RW'(snapCnt_q[band_q]) << (CX_W - 1);
        quo_d   = '0;
        iter_d  = '0;
        state_d = DIV;
      end
      DIV: begin
        if (rem_q >= den_q) begin
          rem_d = rem_q - den_q;
          quo_d = {quo_q[CX_W-2:0], 1'b1};
        end else begin
          quo_d = {quo_q[CX_W-2:0], 1'b0};
        end
        den_d  = den_q >> 1;
        iter_d = iter_q + 4'd1;
        if (iter_q == I_LAST) state_d = STORE;
      end
      STORE: begin
        if (snapCnt_q[band_q] >= CNT_W'(MIN_COUNT)) begin
          cent_d[band_q]     = quo_q;
          roiValid_d[band_q] = 1'b1;
        end else begin
          roiValid_d[band_q] = 1'b0;
        end
        if (band_q == K_LAST) begin
          band_d  = '0;
          state_d = DONE;
          if (roiValid_d[0]) miss_d = '0;
          else if (miss_q != M_MAX) miss_d = miss_q + MW'(1);
          lineLost_d = (miss_d == M_MAX);
        end else begin
          band_d  = band_q + KW'(1);
          state_d = LOAD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      band_q     <= '0;
      iter_q     <= '0;
      rem_q      <= '0;
      den_q      <= '0;
      quo_q      <= '0;
      roiValid_q <= '0;
      miss_q     <= '0;
      lineLost_q <= 1'b0;
      for (int k = 0; k < NUM_ROI; k++) cent_q[k] <= CX_RESET;
    end else begin
      state_q    <= state_d;
      band_q     <= band_d;
      iter_q     <= iter_d;
      rem_q      <= rem_d;
      den_q      <= den_d;
      quo_q      <= quo_d;
      roiValid_q <= roiValid_d;
      miss_q     <= miss_d;
      lineLost_q <= lineLost_d;
      for (int k = 0; k < NUM_ROI; k++) cent_q[k] <= cent_d[k];
    end
  end

  for (genvar k = 0; k < NUM_ROI; k++) begin : g_pack
    assign centroid_x[CX_W*k +: CX_W] = cent_q[k];
  end

  assign roi_valid  = roiValid_q;
  assign line_valid = roiValid_q[0];
  assign line_lost  = lineLost_q;
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign overrun    = frameEnd_q && (state_q != IDLE);

endmodule
